// File: rtl/id_regfile_scoreboard.sv
// id_regfile_scoreboard: decode-stage register file with WB forwarding and RAW busy scoreboard
//
// Ports:
//   Clk, Reset                 clock and synchronous active-high reset (starts the clear sequence)
//   Read_Address_n_ID          read addresses for ports 1 and 2
//   Read_Used_n_ID             operand n is needed by the ID instruction (qualifies the stall)
//   Reserve_Valid_ID/Address   destination reserved by the instruction leaving ID
//   RegWrite_WB, Write_*_WB    write-back port
//   Read_Data_n_ID             combinational read data
//   Stall_ID                   combinational decode stall
//   Ready                      registered, high once the array has been cleared
//
// Build option: define ID_REGFILE_BYPASS_EN to forward WB data to the read ports
// and suppress the stall on a busy register that is being written this cycle.
module id_regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Read_Address_1_ID,
    input  logic [ADDR_W-1:0] Read_Address_2_ID,
    input  logic              Read_Used_1_ID,
    input  logic              Read_Used_2_ID,
    input  logic              Reserve_Valid_ID,
    input  logic [ADDR_W-1:0] Reserve_Address_ID,
    input  logic              RegWrite_WB,
    input  logic [ADDR_W-1:0] Write_Register_WB,
    input  logic [DATA_W-1:0] Write_Data_WB,
    output logic [DATA_W-1:0] Read_Data_1_ID,
    output logic [DATA_W-1:0] Read_Data_2_ID,
    output logic              Stall_ID,
    output logic              Ready
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              run, wr_en, fwd_1, fwd_2, hz_1, hz_2;

    assign run   = state == RUN;
    assign wr_en = RegWrite_WB && Write_Register_WB != '0;

`ifdef ID_REGFILE_BYPASS_EN
    assign fwd_1 = wr_en && Write_Register_WB == Read_Address_1_ID;
    assign fwd_2 = wr_en && Write_Register_WB == Read_Address_2_ID;
`else
    assign fwd_1 = 1'b0;
    assign fwd_2 = 1'b0;
`endif

    // Register 0 is never reserved, so busy[0] stays 0 and needs no special case here
    assign hz_1     = Read_Used_1_ID && busy[Read_Address_1_ID] && !fwd_1;
    assign hz_2     = Read_Used_2_ID && busy[Read_Address_2_ID] && !fwd_2;
    assign Stall_ID = !run || hz_1 || hz_2;

    assign Read_Data_1_ID = (!run || Read_Address_1_ID == '0) ? '0 :
                            fwd_1 ? Write_Data_WB : mem[Read_Address_1_ID];
    assign Read_Data_2_ID = (!run || Read_Address_2_ID == '0) ? '0 :
                            fwd_2 ? Write_Data_WB : mem[Read_Address_2_ID];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= CLEAR;
            ptr   <= ADDR_W'(1);
            busy  <= '0;
            Ready <= 1'b0;
        end else if (state == CLEAR) begin
            ptr <= ptr == LAST ? ptr : ptr + 1'b1;
            if (ptr == LAST) begin
                state <= RUN;
                Ready <= 1'b1;
            end
        end else begin
            if (wr_en)
                busy[Write_Register_WB] <= 1'b0;
            // Placed after the write-back clear so a new producer wins on the same address
            if (Reserve_Valid_ID && Reserve_Address_ID != '0 && !Stall_ID)
                busy[Reserve_Address_ID] <= 1'b1;
        end
    end

    // Storage kept free of reset so it maps onto plain RAM; the clear sequence zeroes it
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == CLEAR)
                mem[ptr] <= '0;
            else if (wr_en)
                mem[Write_Register_WB] <= Write_Data_WB;
        end
    end
endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// tb_id_regfile_scoreboard: directed and random checks of id_regfile_scoreboard against a reference model
module tb_id_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 32;
`ifdef ID_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] a1, a2, ra, wa;
    logic          u1, u2, rv, we;
    logic [DW-1:0] wd, d1, d2;
    logic          st, rdy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_m [D];
    bit            busy_m [D];
    bit            clr_m = 1'b1;
    bit            rdy_m = 1'b0;
    int            cnt_m = 0;
    bit            chk   = 1'b0;

    always #5 clk = ~clk;

    id_regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(clk), .Reset(rst),
        .Read_Address_1_ID(a1), .Read_Address_2_ID(a2),
        .Read_Used_1_ID(u1), .Read_Used_2_ID(u2),
        .Reserve_Valid_ID(rv), .Reserve_Address_ID(ra),
        .RegWrite_WB(we), .Write_Register_WB(wa), .Write_Data_WB(wd),
        .Read_Data_1_ID(d1), .Read_Data_2_ID(d2),
        .Stall_ID(st), .Ready(rdy)
    );

    function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
        if (clr_m || a == 0) return '0;
        if (BYP && we && wa == a) return wd;
        return mem_m[a];
    endfunction

    function automatic bit hz(logic u, logic [AW-1:0] a);
        return u && a != 0 && busy_m[a] && !(BYP && we && wa == a);
    endfunction

    function automatic bit exp_stall();
        return clr_m || hz(u1, a1) || hz(u2, a2);
    endfunction

    task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; a1 = 0; a2 = 0; u1 = 0; u2 = 0; rv = 0; ra = 0; we = 0; wa = 0; wd = 0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge
    task automatic step(string tag);
        bit s;
        @(negedge clk);
        if (chk) begin
            check({tag, " rd1"}, d1, exp_rd(a1));
            check({tag, " rd2"}, d2, exp_rd(a2));
            check({tag, " stall"}, DW'(st), DW'(exp_stall()));
            check({tag, " ready"}, DW'(rdy), DW'(rdy_m));
        end
        @(posedge clk);
        s = exp_stall();
        if (rst) begin
            clr_m = 1; rdy_m = 0; cnt_m = 0;
            for (int i = 0; i < D; i++) busy_m[i] = 0;
        end else if (clr_m) begin
            cnt_m++;
            if (cnt_m == D - 1) begin
                clr_m = 0; rdy_m = 1;
                for (int i = 0; i < D; i++) mem_m[i] = '0;
            end
        end else begin
            if (we && wa != 0) begin
                mem_m[wa]  = wd;
                busy_m[wa] = 0;
            end
            if (rv && ra != 0 && !s) busy_m[ra] = 1;
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        step("reset");
        chk = 1;
        idle();
        // Clear phase with a write attempt on cycle 10
        for (int i = 1; i <= D - 1; i++) begin
            idle();
            a1 = 3; u1 = 1;
            if (i == 10) begin we = 1; wa = 3; wd = 32'hFF; end
            step("clear");
        end
        idle(); a1 = 3; #1;
        check("plan clear-write ignored", d1, 32'h0);
        check("plan ready after clear", DW'(rdy), 32'h1);
        step("after clear");

        idle(); we = 1; wa = 5; wd = 32'hDEADBEEF; step("wr5");
        idle(); a1 = 5; #1;
        check("plan rd5 before reset", d1, 32'hDEADBEEF);
        step("rd5");
        idle(); rst = 1; step("mid reset");
        for (int i = 0; i < D - 1; i++) begin
            idle(); a1 = 5; step("reclear");
        end
        idle(); a1 = 5; #1;
        check("plan rd5 after reset", d1, 32'h0);
        check("plan ready after reset", DW'(rdy), 32'h1);
        step("rd5 post");

        idle(); we = 1; wa = 0; wd = 32'h12345678; step("wr0");
        idle(); a1 = 0; step("rd0");
        idle(); rv = 1; ra = 0; step("rsv0");
        idle(); a1 = 0; u1 = 1; #1;
        check("plan r0 no stall", DW'(st), 32'h0);
        step("rd0 used");

        idle(); rv = 1; ra = 7; step("rsv7");
        idle(); a1 = 7; u1 = 1; #1;
        check("plan busy7 stall", DW'(st), 32'h1);
        step("rd7 used");
        idle(); a1 = 7; u1 = 0; #1;
        check("plan busy7 unused", DW'(st), 32'h0);
        step("rd7 unused");

        idle(); a2 = 7; u2 = 1; we = 1; wa = 7; wd = 32'hCAFEF00D; #1;
        check("plan wb7 stall", DW'(st), DW'(!BYP));
        if (BYP) check("plan wb7 fwd", d2, 32'hCAFEF00D);
        step("wb7");
        idle(); a2 = 7; u2 = 1; #1;
        check("plan wb7 next stall", DW'(st), 32'h0);
        check("plan wb7 next data", d2, 32'hCAFEF00D);
        step("wb7 next");

        idle(); rv = 1; ra = 9; we = 1; wa = 9; wd = 32'h55; step("rsv+wb9");
        idle(); a1 = 9; u1 = 1; #1;
        check("plan busy9 stall", DW'(st), 32'h1);
        step("rd9 used");
        idle(); a1 = 9; #1;
        check("plan entry9", d1, 32'h55);
        step("rd9");

        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(0, 149) == 0;
            a1 = AW'($urandom_range(0, 7)); a2 = AW'($urandom_range(0, 7));
            u1 = 1'($urandom); u2 = 1'($urandom);
            rv = $urandom_range(0, 2) == 0; ra = AW'($urandom_range(0, 7));
            we = $urandom_range(0, 1) == 0; wa = AW'($urandom_range(0, 7));
            wd = $urandom;
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_regfile_scoreboard.md
# id_regfile_scoreboard

Parametrised decode-stage register file for the MIPS32 pipeline: two combinational read ports, one clocked write-back port, address-compare WB-to-ID forwarding, and a per-register busy scoreboard that raises a decode stall on read-after-write hazards. A synchronous-reset clear sequencer zeroes the array one entry per cycle, so no memory-init file is needed. It sits between the ID stage (reads, destination reservation) and the WB stage (write-back).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high; starts the clear sequence
- Read_Address_1_ID  in  ADDR_W  port-1 read address
- Read_Address_2_ID  in  ADDR_W  port-2 read address
- Read_Used_1_ID  in  1  port-1 operand needed by the instruction in ID (qualifies stall)
- Read_Used_2_ID  in  1  port-2 operand needed
- Reserve_Valid_ID  in  1  instruction leaving ID will write Reserve_Address_ID
- Reserve_Address_ID  in  ADDR_W  destination being reserved
- RegWrite_WB  in  1  write-back strobe
- Write_Register_WB  in  ADDR_W  write-back address
- Write_Data_WB  in  DATA_W  write-back data
- Read_Data_1_ID  out  DATA_W  port-1 data (combinational)
- Read_Data_2_ID  out  DATA_W  port-2 data (combinational)
- Stall_ID  out  1  hold the ID stage this cycle (combinational)
- Ready  out  1  clear sequence finished; registered

## Operation
- Register 0: reads always return 0; writes and reservations to address 0 ignored; its busy bit is never set.
- States: CLEAR, RUN. Reset (any cycle, including mid-clear) forces CLEAR, clear pointer = 1, all busy bits = 0, Ready = 0.
- CLEAR: each cycle write 0 to entry[pointer], pointer increments; at pointer = DEPTH-1 write it and go to RUN next cycle. WB writes and reservations ignored. Read data = 0, Stall_ID = 1.
- RUN: Ready = 1.
  - Write: on posedge, if RegWrite_WB and Write_Register_WB != 0, entry <= Write_Data_WB and busy[addr] <= 0.
  - Reserve: on posedge, if Reserve_Valid_ID and Reserve_Address_ID != 0 and Stall_ID = 0, busy[addr] <= 1. Reserve and write to the same address in one cycle: busy ends 1 (new producer wins); the data write still happens.
  - Read port n: address 0 -> 0; else if forward match (RegWrite_WB, Write_Register_WB equal to read address, nonzero) -> Write_Data_WB; else array entry.
  - Hazard on port n: Read_Used_n_ID and busy[addr] and not forward-satisfied.
  - Stall_ID = hazard on port 1 OR hazard on port 2.
- Arithmetic: pointer is ADDR_W bits; no wrap beyond DEPTH-1. Data passes through unmodified.

## Timing
- Reset values: Ready 0, busy all 0, pointer 1; Read_Data_* 0 and Stall_ID 1 while in CLEAR.
- Clear latency: after Reset deasserts, Ready rises DEPTH-1 cycles later (31 cycles for ADDR_W = 5); entries hold 0 from then on.
- Read latency 0 (combinational from addresses and WB inputs); write visible in array 1 cycle after strobe, and same cycle via forwarding.
- Stall_ID depends combinationally on read addresses, Read_Used_*, WB inputs, busy state; no path from Reserve_* to Stall_ID.

## Configuration
- ID_REGFILE_BYPASS_EN defined: forward match as above; a busy register being written this cycle gives no stall, data = Write_Data_WB.
- Not defined: no forwarding; reads return array entry only; a busy register stalls until the cycle after its write-back (busy clear takes effect), adding one stall cycle per such hazard.

## Test plan
- Reset 1 cycle mid-run with entry 5 = 0xDEADBEEF -> Ready 0 for 31 cycles, Stall_ID 1, then read 5 = 0x00000000, Ready 1.
- Write 0x12345678 to 0, read 0 -> 0x00000000; busy[0] never set after Reserve to 0.
- Reserve 7, next cycle read 7 with Read_Used_1_ID = 1 -> Stall_ID 1; same read with Read_Used_1_ID = 0 -> Stall_ID 0.
- Busy 7, WB writes 0xCAFEF00D to 7 while port 2 reads 7 -> with macro: Stall_ID 0, Read_Data_2_ID 0xCAFEF00D; without: Stall_ID 1 that cycle, 0 next cycle with data 0xCAFEF00D.
- Same cycle Reserve 9 and WB write 0x55 to 9 -> entry 9 = 0x55, busy[9] = 1, next read of 9 stalls.
- Write during CLEAR (cycle 10, addr 3, 0xFF) -> ignored; after Ready, read 3 = 0.
